// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared types and constants for the pipeline control tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int TAG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic [TAG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } stage_tag_t;

    localparam logic [TAG_AW-1:0] REG_ZERO   = '0;
    localparam stage_tag_t        BUBBLE_TAG = '0;

    // x0 is never a real destination, so its write enable is dropped on entry.
    function automatic stage_tag_t canon_tag(
        input logic              valid,
        input logic [TAG_AW-1:0] rd,
        input logic              regwrite,
        input logic              memread
    );
        stage_tag_t t;
        t.valid    = valid;
        t.rd       = rd;
        t.regwrite = regwrite & valid & (rd != REG_ZERO);
        t.memread  = memread & valid;
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/stage_tag_reg.sv
// ============================================================================
// Module : stage_tag_reg
// Brief  : One pipeline tag register with sync reset and flush-to-bubble.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stage_tag_reg
    import pipe_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  stage_tag_t i_tag,
    output stage_tag_t o_tag
);

    stage_tag_t r_tag;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_tag <= BUBBLE_TAG;
        end else begin
            r_tag <= i_tag;
        end
    end

    assign o_tag = r_tag;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl_tracker.sv
// ============================================================================
// Module : pipe_ctrl_tracker
// Brief  : Carries rd/RegWrite/MemRead tags D->E->M->W, detects load-use and
//          branch hazards. Optional HAZARD_PERF_CNT_EN adds hazard counters.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidD,
    input  logic [REG_AW-1:0] RS1D,
    input  logic [REG_AW-1:0] RS2D,
    input  logic [REG_AW-1:0] RDD,
    input  logic              RegWriteD,
    input  logic              MemReadD,
    input  logic              PCSrcE,
    output logic [REG_AW-1:0] RS1E,
    output logic [REG_AW-1:0] RS2E,
    output logic [REG_AW-1:0] RDE,
    output logic [REG_AW-1:0] RDM,
    output logic [REG_AW-1:0] RDW,
    output logic              RegWriteM,
    output logic              RegWriteW,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
`endif
);

    // A mismatched configuration instantiates an undefined module on purpose.
    generate
        if ((REG_AW != TAG_AW) || (NUM_REGS != (1 << REG_AW))) begin : g_bad_cfg
            pipe_ctrl_tracker_bad_parameters u_bad ();
        end
    endgenerate

    stage_tag_t        w_tag_d;
    stage_tag_t        w_tag_e;
    stage_tag_t        w_tag_m;
    stage_tag_t        w_tag_w;
    logic [REG_AW-1:0] r_rs1_e;
    logic [REG_AW-1:0] r_rs2_e;
    logic              w_lw_stall;
    logic              w_flush_e;

    assign w_tag_d = canon_tag(ValidD, RDD, RegWriteD, MemReadD);

    assign w_lw_stall = w_tag_e.memread & w_tag_e.valid & (w_tag_e.rd != REG_ZERO)
                      & ((w_tag_e.rd == RS1D) | (w_tag_e.rd == RS2D)) & ValidD;
    assign w_flush_e  = w_lw_stall | PCSrcE;

    stage_tag_reg u_tag_e (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_flush_e),
        .i_tag   (w_tag_d),
        .o_tag   (w_tag_e)
    );

    stage_tag_reg u_tag_m (
        .clk     (clk),
        .rst     (reset),
        .i_flush (1'b0),
        .i_tag   (w_tag_e),
        .o_tag   (w_tag_m)
    );

    stage_tag_reg u_tag_w (
        .clk     (clk),
        .rst     (reset),
        .i_flush (1'b0),
        .i_tag   (w_tag_m),
        .o_tag   (w_tag_w)
    );

    always_ff @(posedge clk) begin
        if (reset || w_flush_e) begin
            r_rs1_e <= '0;
            r_rs2_e <= '0;
        end else begin
            r_rs1_e <= RS1D;
            r_rs2_e <= RS2D;
        end
    end

    // Tags only clear on the reset edge, so outputs are masked during reset.
    assign RS1E      = reset ? '0 : r_rs1_e;
    assign RS2E      = reset ? '0 : r_rs2_e;
    assign RDE       = reset ? '0 : w_tag_e.rd;
    assign RDM       = reset ? '0 : w_tag_m.rd;
    assign RDW       = reset ? '0 : w_tag_w.rd;
    assign RegWriteM = ~reset & w_tag_m.regwrite;
    assign RegWriteW = ~reset & w_tag_w.regwrite;

    // A taken branch discards the stalled instruction, so flush wins.
    assign StallF    = ~reset & w_lw_stall & ~PCSrcE;
    assign StallD    = ~reset & w_lw_stall & ~PCSrcE;
    assign FlushD    = ~reset & PCSrcE;
    assign FlushE    = ~reset & w_flush_e;

    logic w_unused;
    assign w_unused = ^{w_tag_e.regwrite, w_tag_m.valid, w_tag_m.memread,
                        w_tag_w.valid, w_tag_w.memread};

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lw_stall && !PCSrcE && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (PCSrcE && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl_tracker.sv
// ============================================================================
// Module : tb_pipe_ctrl_tracker
// Brief  : Directed self-checking bench with a pipeline model for the tracker.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       ValidD, RegWriteD, MemReadD, PCSrcE;
    logic [4:0] RS1D, RS2D, RDD;
    logic [4:0] RS1E, RS2E, RDE, RDM, RDW;
    logic       RegWriteM, RegWriteW, StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] StallCount, FlushCount;
`endif

    always #5 clk = ~clk;

    pipe_ctrl_tracker #(.REG_AW(5), .NUM_REGS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .ValidD    (ValidD),
        .RS1D      (RS1D),
        .RS2D      (RS2D),
        .RDD       (RDD),
        .RegWriteD (RegWriteD),
        .MemReadD  (MemReadD),
        .PCSrcE    (PCSrcE),
        .RS1E      (RS1E),
        .RS2E      (RS2E),
        .RDE       (RDE),
        .RDM       (RDM),
        .RDW       (RDW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCount(StallCount),
        .FlushCount(FlushCount)
`endif
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: index 0 = Execute, 1 = Memory, 2 = Writeback
    bit         mv [3]  = '{0, 0, 0};
    bit         mrw[3]  = '{0, 0, 0};
    bit         mmr[3]  = '{0, 0, 0};
    logic [4:0] mrd[3]  = '{5'd0, 5'd0, 5'd0};
    logic [4:0] ers1    = 5'd0;
    logic [4:0] ers2    = 5'd0;
    logic [31:0] mstall = 32'd0;
    logic [31:0] mflush = 32'd0;

    function automatic bit model_lw();
        return mmr[0] && mv[0] && (mrd[0] != 5'd0) &&
               ((mrd[0] == RS1D) || (mrd[0] == RS2D)) && ValidD;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit lw;
        lw = model_lw();
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                mv[i] = 0; mrw[i] = 0; mmr[i] = 0; mrd[i] = 5'd0;
            end
            ers1 = 5'd0; ers2 = 5'd0; mstall = 32'd0; mflush = 32'd0;
        end else begin
            if (lw && !PCSrcE && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
            if (PCSrcE && mflush != 32'hFFFF_FFFF) mflush = mflush + 1;
            for (int i = 2; i > 0; i--) begin
                mv[i] = mv[i-1]; mrw[i] = mrw[i-1]; mmr[i] = mmr[i-1]; mrd[i] = mrd[i-1];
            end
            if (lw || PCSrcE) begin
                mv[0] = 0; mrw[0] = 0; mmr[0] = 0; mrd[0] = 5'd0; ers1 = 5'd0; ers2 = 5'd0;
            end else begin
                mv[0]  = ValidD;
                mrd[0] = RDD;
                mrw[0] = RegWriteD && ValidD && (RDD != 5'd0);
                mmr[0] = MemReadD && ValidD;
                ers1   = RS1D;
                ers2   = RS2D;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit lw, r;
            lw = model_lw();
            r  = reset;
            chk("StallF",    StallF,    !r && lw && !PCSrcE);
            chk("StallD",    StallD,    !r && lw && !PCSrcE);
            chk("FlushD",    FlushD,    !r && PCSrcE);
            chk("FlushE",    FlushE,    !r && (lw || PCSrcE));
            chk("RS1E",      RS1E,      r ? 5'd0 : ers1);
            chk("RS2E",      RS2E,      r ? 5'd0 : ers2);
            chk("RDE",       RDE,       r ? 5'd0 : mrd[0]);
            chk("RDM",       RDM,       r ? 5'd0 : mrd[1]);
            chk("RDW",       RDW,       r ? 5'd0 : mrd[2]);
            chk("RegWriteM", RegWriteM, !r && mrw[1]);
            chk("RegWriteW", RegWriteW, !r && mrw[2]);
`ifdef HAZARD_PERF_CNT_EN
            chk("StallCount", StallCount, mstall);
            chk("FlushCount", FlushCount, mflush);
`endif
        end
    end

    task automatic step(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input bit rw, input bit mr,
                        input bit pc, input bit rst);
        @(posedge clk);
        #1;
        ValidD = v; RS1D = rs1; RS2D = rs2; RDD = rd;
        RegWriteD = rw; MemReadD = mr; PCSrcE = pc; reset = rst;
        @(negedge clk);
        #1;
    endtask

    task automatic nop();
        step(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; ValidD = 0; RS1D = 0; RS2D = 0; RDD = 0;
        RegWriteD = 0; MemReadD = 0; PCSrcE = 0;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        cmp_en = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_rst_RDE", RDE, 5'd0);
        chk("lit_rst_StallF", StallF, 1'b0);

        // Reset with three instructions in flight
        step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        step(1, 5'd1, 5'd2, 5'd4, 1, 0, 0, 0);
        step(1, 5'd10, 5'd11, 5'd5, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit_midrst_RDE_gated", RDE, 5'd0);
        nop();
        chk("lit_postrst_RDE", RDE, 5'd0);
        chk("lit_postrst_RDM", RDM, 5'd0);
        chk("lit_postrst_RDW", RDW, 5'd0);
        chk("lit_postrst_RegWriteM", RegWriteM, 1'b0);
        chk("lit_postrst_RegWriteW", RegWriteW, 1'b0);
        chk("lit_postrst_FlushE", FlushE, 1'b0);

        // lw x5 then dependent add x6,x5,x7
        step(1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0);
        step(1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 0);
        chk("lit_lu_StallF", StallF, 1'b1);
        chk("lit_lu_StallD", StallD, 1'b1);
        chk("lit_lu_FlushE", FlushE, 1'b1);
        chk("lit_lu_FlushD", FlushD, 1'b0);
        step(1, 5'd5, 5'd7, 5'd6, 1, 0, 0, 0);
        chk("lit_lu_held_StallF", StallF, 1'b0);
        chk("lit_lu_bubble_RDE", RDE, 5'd0);
        nop();
        chk("lit_lu_add_RDE", RDE, 5'd6);
        chk("lit_lu_RDW", RDW, 5'd5);
        chk("lit_lu_RegWriteW", RegWriteW, 1'b1);
        nop();
        chk("lit_lu_add_RDM", RDM, 5'd6);

        // Independent add x3; sub x4
        step(1, 5'd1, 5'd2, 5'd3, 1, 0, 0, 0);
        step(1, 5'd8, 5'd9, 5'd4, 1, 0, 0, 0);
        chk("lit_ind_RDE", RDE, 5'd3);
        chk("lit_ind_StallF", StallF, 1'b0);
        nop();
        chk("lit_ind_RDM", RDM, 5'd3);
        chk("lit_ind_RegWriteM", RegWriteM, 1'b1);
        chk("lit_ind_RDE2", RDE, 5'd4);
        nop();
        chk("lit_ind_RDW", RDW, 5'd3);
        chk("lit_ind_RegWriteW", RegWriteW, 1'b1);
        chk("lit_ind_RDM2", RDM, 5'd4);
        nop();
        chk("lit_ind_RDW2", RDW, 5'd4);

        // Branch together with a load-use pair: flush wins
        step(1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0);
        step(1, 5'd5, 5'd7, 5'd6, 1, 0, 1, 0);
        chk("lit_br_FlushD", FlushD, 1'b1);
        chk("lit_br_FlushE", FlushE, 1'b1);
        chk("lit_br_StallF", StallF, 1'b0);
        chk("lit_br_StallD", StallD, 1'b0);
        nop();
        chk("lit_br_RegWriteM", RegWriteM, 1'b1);
        chk("lit_br_RDM", RDM, 5'd5);
        chk("lit_br_RDE", RDE, 5'd0);

        // addi x0,x0,1
        step(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0);
        nop();
        nop();
        chk("lit_x0_RegWriteM", RegWriteM, 1'b0);
        chk("lit_x0_RDM", RDM, 5'd0);
        nop();
        chk("lit_x0_RegWriteW", RegWriteW, 1'b0);
        chk("lit_x0_RDW", RDW, 5'd0);

        // Back-to-back dependent loads, then a consumer of the second load
        step(1, 5'd1, 5'd0, 5'd5, 1, 1, 0, 0);
        step(1, 5'd5, 5'd0, 5'd6, 1, 1, 0, 0);
        chk("lit_b2b_stall1", StallF, 1'b1);
        step(1, 5'd5, 5'd0, 5'd6, 1, 1, 0, 0);
        chk("lit_b2b_nostall", StallF, 1'b0);
        step(1, 5'd6, 5'd2, 5'd7, 1, 0, 0, 0);
        chk("lit_b2b_stall2", StallF, 1'b1);
        step(1, 5'd6, 5'd2, 5'd7, 1, 0, 0, 0);
        chk("lit_b2b_nostall2", StallF, 1'b0);
        nop();

        // One more load-use via rs2, and a plain taken branch
        step(1, 5'd3, 5'd0, 5'd8, 1, 1, 0, 0);
        step(1, 5'd4, 5'd8, 5'd9, 1, 0, 0, 0);
        chk("lit_rs2_stall", StallD, 1'b1);
        step(1, 5'd4, 5'd8, 5'd9, 1, 0, 0, 0);
        step(1, 5'd1, 5'd2, 5'd10, 1, 0, 1, 0);
        chk("lit_br2_FlushD", FlushD, 1'b1);
        nop();
        nop();
        nop();
`ifdef HAZARD_PERF_CNT_EN
        chk("lit_StallCount", StallCount, 32'd4);
        chk("lit_FlushCount", FlushCount, 32'd2);
`endif
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
